pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised fetch-stage PC sequencer: holds architectural PC, computes next PC
//  (sequential, PC-relative I/D, register-indirect), owns EPC, SIIC vectoring and RTI.
//  Sits between decode/execute redirect logic and instruction memory address port.
//  Adds stall hold, halt state, exception nesting check and reserved-mode error.
// PARAMETERS
//  WIDTH      16       PC/data width (>= IMM_D_W+1)
//  IMM_I_W    8        width of short immediate (sign-extended)
//  IMM_D_W    11       width of displacement immediate (sign-extended)
//  INSN_BYTES 2        sequential increment
//  RESET_PC   0        PC value after reset
//  EXC_VECTOR 'h0002   SIIC handler address
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        asynchronous, active-high reset
//  stall       in   1        hold PC (pipeline not accepting fetch)
//  redir_valid in   1        taken branch/jump from execute this cycle
//  redir_mode  in   2        00 base_pc+I, 01 base_pc+D, 10 rs+I, 11 reserved
//  redir_pc2   in   WIDTH    PC+INSN_BYTES of redirecting instruction
//  rs          in   WIDTH    register operand for indirect jump
//  imm_i       in   IMM_I_W  short immediate
//  imm_d       in   IMM_D_W  displacement immediate
//  siic        in   1        illegal-instruction trap; redir_pc2 = trapping PC+2
//  rti         in   1        return from interrupt
//  halt        in   1        stop fetching
//  pc          out  WIDTH    current fetch address (register)
//  pc_plus     out  WIDTH    pc + INSN_BYTES (combinational)
//  epc         out  WIDTH    exception PC register
//  fetch_valid out  1        pc is a valid fetch this cycle
//  in_handler  out  1        EPC live (inside SIIC handler)
//  err         out  1        one-cycle error pulse (registered)
// BEHAVIOUR
//  Reset (async): pc=RESET_PC, epc=0, state=RUN, fetch_valid=0 for first cycle
//   after deassert then 1, in_handler=0, err=0.
//  States: RUN, VEC (one bubble cycle after SIIC), HALTED.
//  Per-edge priority in RUN: halt > siic > rti > redir_valid > stall > sequential.
//   halt: pc holds, -> HALTED, fetch_valid=0; only rst exits HALTED.
//   siic: epc<=redir_pc2, pc<=EXC_VECTOR, in_handler<=1, -> VEC (fetch_valid=0 1 cyc).
//     siic while in_handler=1: epc NOT overwritten, err pulses, still vectors.
//   rti: pc<=epc, in_handler<=0. rti with in_handler=0: err pulses, pc<=epc anyway.
//   redir_valid: pc<=target; mode 11: pc<=pc_plus, err pulses.
//   stall: pc holds, fetch_valid stays 1; redirect/siic/rti/halt override stall.
//   else pc<=pc_plus.
//  VEC -> RUN next cycle unconditionally; inputs ignored in VEC except rst.
//  Target: base + sext(imm); base = redir_pc2 (modes 00/01) or rs (mode 10).
//  All adds modulo 2**WIDTH; carry-out discarded, no error (0xFFFE+2 -> 0x0000).
//  Latency: redirect/siic/rti visible on pc one cycle after the asserting edge.
//  err is high exactly one cycle per offending event; never sticky.
//  Mid-operation rst: immediate return to reset values regardless of state.
// STRUCTURE
//  pc_pkg: redir_mode encodings (MODE_I, MODE_D, MODE_RS_I, MODE_RSVD), state
//   encodings (ST_RUN, ST_VEC, ST_HALT).
//  Sub-module pc_target_adder (combinational): sign-extend, base mux, adder.
//  Top: pc/epc/state/in_handler/err registers and priority next-state logic.
// TESTING
//  Reset then 4 free cycles -> pc 0,2,4,6; fetch_valid 0 on first cycle then 1.
//  redir_pc2=0x0010, mode 00, imm_i=0xFC -> pc=0x000C; mode 01 imm_d=0x7FF -> 0x000F.
//  Mode 10, rs=0xFFFE, imm_i=0x04 -> pc=0x0002 (wrap), err stays 0.
//  siic at redir_pc2=0x0044 -> epc=0x0044, pc=0x0002, 1 bubble; rti -> pc=0x0044.
//  Nested siic while in_handler -> epc unchanged, err 1 cycle; mode 11 -> err, pc+2.
//  stall+redir same cycle -> redirect wins; halt -> pc frozen; rst mid-VEC -> pc=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings for the fetch-stage PC sequencer: redirect addressing modes
// and sequencer control states.
package pc_pkg;

  localparam logic [1:0] MODE_I    = 2'b00;
  localparam logic [1:0] MODE_D    = 2'b01;
  localparam logic [1:0] MODE_RS_I = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_VEC  = 2'b01,
    ST_HALT = 2'b10
  } pc_state_e;

endpackage

// File: rtl/pc_target_adder.sv
// Redirect target generation: picks the base (link PC or register), sign-extends
// the immediate that goes with the mode and adds modulo 2**WIDTH.
module pc_target_adder
  import pc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int IMM_I_W = 8,
  parameter int IMM_D_W = 11
) (
  input  logic [1:0]         mode_i,
  input  logic [WIDTH-1:0]   pc2_i,
  input  logic [WIDTH-1:0]   rs_i,
  input  logic [IMM_I_W-1:0] imm_i_i,
  input  logic [IMM_D_W-1:0] imm_d_i,
  output logic [WIDTH-1:0]   target_o
);

  logic signed [WIDTH-1:0] sext_i;
  logic signed [WIDTH-1:0] sext_d;
  logic [WIDTH-1:0]        base;
  logic [WIDTH-1:0]        offs;

  assign sext_i = {{(WIDTH-IMM_I_W){imm_i_i[IMM_I_W-1]}}, imm_i_i};
  assign sext_d = {{(WIDTH-IMM_D_W){imm_d_i[IMM_D_W-1]}}, imm_d_i};

  // Reserved mode yields a don't-care target; the sequencer substitutes pc_plus.
  always_comb begin
    base = pc2_i;
    offs = sext_i;
    case (mode_i)
      MODE_D:    offs = sext_d;
      MODE_RS_I: base = rs_i;
      default:   ;
    endcase
  end

  assign target_o = base + offs;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: architectural PC, EPC, SIIC vectoring, RTI, stall,
// halt and one-cycle error pulses for nesting/RTI/reserved-mode misuse.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter int               IMM_I_W    = 8,
  parameter int               IMM_D_W    = 11,
  parameter int               INSN_BYTES = 2,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'('h0002)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redir_valid,
  input  logic [1:0]         redir_mode,
  input  logic [WIDTH-1:0]   redir_pc2,
  input  logic [WIDTH-1:0]   rs,
  input  logic [IMM_I_W-1:0] imm_i,
  input  logic [IMM_D_W-1:0] imm_d,
  input  logic               siic,
  input  logic               rti,
  input  logic               halt,
  output logic [WIDTH-1:0]   pc,
  output logic [WIDTH-1:0]   pc_plus,
  output logic [WIDTH-1:0]   epc,
  output logic               fetch_valid,
  output logic               in_handler,
  output logic               err
);

  pc_state_e        state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] epc_q;
  logic             fv_q;
  logic             inh_q;
  logic             err_q;
  logic [WIDTH-1:0] target;

  assign pc_plus = pc_q + WIDTH'(INSN_BYTES);

  pc_target_adder #(
    .WIDTH  (WIDTH),
    .IMM_I_W(IMM_I_W),
    .IMM_D_W(IMM_D_W)
  ) u_target (
    .mode_i  (redir_mode),
    .pc2_i   (redir_pc2),
    .rs_i    (rs),
    .imm_i_i (imm_i),
    .imm_d_i (imm_d),
    .target_o(target)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      fv_q    <= 1'b0;
      inh_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_HALT: fv_q <= 1'b0;
        // Bubble cycle: pc already sits on the vector, fetch resumes next cycle.
        ST_VEC: begin
          state_q <= ST_RUN;
          fv_q    <= 1'b1;
        end
        default: begin
          fv_q <= 1'b1;
          if (halt) begin
            state_q <= ST_HALT;
            fv_q    <= 1'b0;
          end else if (siic) begin
            if (inh_q) err_q <= 1'b1;
            else       epc_q <= redir_pc2;
            pc_q    <= EXC_VECTOR;
            inh_q   <= 1'b1;
            state_q <= ST_VEC;
            fv_q    <= 1'b0;
          end else if (rti) begin
            pc_q  <= epc_q;
            inh_q <= 1'b0;
            err_q <= ~inh_q;
          end else if (redir_valid) begin
            if (redir_mode == MODE_RSVD) begin
              pc_q  <= pc_plus;
              err_q <= 1'b1;
            end else begin
              pc_q <= target;
            end
          end else if (!stall) begin
            pc_q <= pc_plus;
          end
        end
      endcase
    end
  end

  assign pc          = pc_q;
  assign epc         = epc_q;
  assign fetch_valid = fv_q;
  assign in_handler  = inh_q;
  assign err         = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

  localparam int WIDTH = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall, redir_valid, siic, rti, halt;
  logic [1:0]        redir_mode;
  logic [WIDTH-1:0]  redir_pc2, rs;
  logic [7:0]        imm_i;
  logic [10:0]       imm_d;
  logic [WIDTH-1:0]  pc, pc_plus, epc;
  logic              fetch_valid, in_handler, err;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redir_valid(redir_valid),
    .redir_mode (redir_mode),
    .redir_pc2  (redir_pc2),
    .rs         (rs),
    .imm_i      (imm_i),
    .imm_d      (imm_d),
    .siic       (siic),
    .rti        (rti),
    .halt       (halt),
    .pc         (pc),
    .pc_plus    (pc_plus),
    .epc        (epc),
    .fetch_valid(fetch_valid),
    .in_handler (in_handler),
    .err        (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 0; redir_valid = 0; siic = 0; rti = 0; halt = 0;
    redir_mode = 2'b00; redir_pc2 = '0; rs = '0; imm_i = '0; imm_d = '0;
    step(); step();
    check_eq("rst_pc", pc, 16'h0000);
    check_eq("rst_epc", epc, 16'h0000);
    check_eq("rst_fv", fetch_valid, 1'b0);
    check_eq("rst_inh", in_handler, 1'b0);
    check_eq("rst_err", err, 1'b0);

    rst = 1'b0;
    #1;
    check_eq("free0_pc", pc, 16'h0000);
    check_eq("free0_fv", fetch_valid, 1'b0);
    step(); check_eq("free1_pc", pc, 16'h0002); check_eq("free1_fv", fetch_valid, 1'b1);
    step(); check_eq("free2_pc", pc, 16'h0004);
    step(); check_eq("free3_pc", pc, 16'h0006);
    check_eq("pc_plus", pc_plus, 16'h0008);

    redir_valid = 1; redir_mode = 2'b00; redir_pc2 = 16'h0010; imm_i = 8'hFC;
    step(); check_eq("mode00_pc", pc, 16'h000C);
    redir_mode = 2'b01; imm_d = 11'h7FF;
    step(); check_eq("mode01_pc", pc, 16'h000F);
    redir_mode = 2'b10; rs = 16'hFFFE; imm_i = 8'h04;
    step(); check_eq("mode10_wrap_pc", pc, 16'h0002); check_eq("mode10_err", err, 1'b0);
    redir_valid = 0;

    siic = 1; redir_pc2 = 16'h0044;
    step();
    check_eq("siic_epc", epc, 16'h0044); check_eq("siic_pc", pc, 16'h0002);
    check_eq("siic_fv", fetch_valid, 1'b0); check_eq("siic_inh", in_handler, 1'b1);
    check_eq("siic_err", err, 1'b0);
    siic = 0; redir_valid = 1; redir_mode = 2'b00; redir_pc2 = 16'h0200; imm_i = 8'h00;
    step(); check_eq("vec_pc", pc, 16'h0002); check_eq("vec_fv", fetch_valid, 1'b1);
    redir_valid = 0;
    step(); check_eq("hnd_seq_pc", pc, 16'h0004);

    siic = 1; redir_pc2 = 16'h0080;
    step();
    check_eq("nest_epc", epc, 16'h0044); check_eq("nest_err", err, 1'b1);
    check_eq("nest_pc", pc, 16'h0002);
    siic = 0;
    step(); check_eq("nest_err_clr", err, 1'b0);
    rti = 1;
    step();
    check_eq("rti_pc", pc, 16'h0044); check_eq("rti_inh", in_handler, 1'b0);
    check_eq("rti_err", err, 1'b0);
    step();
    check_eq("rti_bad_err", err, 1'b1); check_eq("rti_bad_pc", pc, 16'h0044);
    rti = 0;
    step(); check_eq("rti_bad_clr", err, 1'b0); check_eq("rti_seq_pc", pc, 16'h0046);

    redir_valid = 1; redir_mode = 2'b11;
    step(); check_eq("rsvd_pc", pc, 16'h0048); check_eq("rsvd_err", err, 1'b1);
    redir_valid = 0;
    step(); check_eq("rsvd_clr", err, 1'b0); check_eq("rsvd_seq_pc", pc, 16'h004A);

    stall = 1;
    step(); check_eq("stall_pc", pc, 16'h004A); check_eq("stall_fv", fetch_valid, 1'b1);
    redir_valid = 1; redir_mode = 2'b00; redir_pc2 = 16'h0100; imm_i = 8'h10;
    step(); check_eq("stall_redir_pc", pc, 16'h0110);
    redir_valid = 0; stall = 0;

    halt = 1;
    step(); check_eq("halt_pc", pc, 16'h0110); check_eq("halt_fv", fetch_valid, 1'b0);
    halt = 0; redir_valid = 1;
    step(); check_eq("halted_pc", pc, 16'h0110); check_eq("halted_fv", fetch_valid, 1'b0);
    redir_valid = 0;
    step(); check_eq("halted_pc2", pc, 16'h0110);

    rst = 1; #1; rst = 0;
    check_eq("halt_rst_pc", pc, 16'h0000);
    step(); check_eq("post_rst_pc", pc, 16'h0002);
    siic = 1; redir_pc2 = 16'h0020;
    step(); check_eq("vec2_pc", pc, 16'h0002); check_eq("vec2_epc", epc, 16'h0020);
    siic = 0;
    #2; rst = 1; #1;
    check_eq("vec_rst_pc", pc, 16'h0000);
    check_eq("vec_rst_epc", epc, 16'h0000);
    check_eq("vec_rst_inh", in_handler, 1'b0);
    check_eq("vec_rst_fv", fetch_valid, 1'b0);
    step(); rst = 0;
    step(); check_eq("vec_rst_run_pc", pc, 16'h0002); check_eq("vec_rst_run_fv", fetch_valid, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
